id_scoreboard: RTL

ID_SCOREBOARD -- requirements
Module: id_scoreboard

---
 rtl/id_pkg.sv | 16 +
 rtl/id_scoreboard_if.sv | 24 ++
 rtl/id_sb_counter.sv | 37 +++
 rtl/id_scoreboard.sv | 72 +++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the integer-register write scoreboard.
package id_pkg;
  localparam int unsigned C_NREGS_DEF    = 32;
  localparam int unsigned C_MAX_PEND_DEF = 3;
  localparam int unsigned AW             = 5;
  localparam int unsigned CNT_W          = $clog2(C_MAX_PEND_DEF + 1);

  typedef logic [AW-1:0]    addr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Number of writeback ports (0..2) retiring register a this cycle.
  function automatic logic [1:0] wb_hits(input addr_t a, input logic wa_wr, input addr_t wa,
                                         input logic wb_wr, input addr_t wb);
    return {1'b0, wa_wr && (wa == a)} + {1'b0, wb_wr && (wb == a)};
  endfunction
endpackage

// File: rtl/id_scoreboard_if.sv
// Issue/writeback/status bundle between decode and the scoreboard.
interface id_scoreboard_if;
  import id_pkg::*;
  logic  issue_valid_i, issue_ready_o;
  logic  rs1_rd_i, rs2_rd_i;
  addr_t rs1_addr_i, rs2_addr_i;
  logic  rd_wr_i;
  addr_t rd_addr_i;
  logic  wb_a_wr_i, wb_b_wr_i;
  addr_t wb_a_addr_i, wb_b_addr_i;
  logic  flush_i;
  logic  hazard_o, busy_o, err_o;

  modport master (
    output issue_valid_i, rs1_rd_i, rs2_rd_i, rs1_addr_i, rs2_addr_i, rd_wr_i, rd_addr_i,
           wb_a_wr_i, wb_b_wr_i, wb_a_addr_i, wb_b_addr_i, flush_i,
    input  issue_ready_o, hazard_o, busy_o, err_o
  );
  modport slave (
    input  issue_valid_i, rs1_rd_i, rs2_rd_i, rs1_addr_i, rs2_addr_i, rd_wr_i, rd_addr_i,
           wb_a_wr_i, wb_b_wr_i, wb_a_addr_i, wb_b_addr_i, flush_i,
    output issue_ready_o, hazard_o, busy_o, err_o
  );
endinterface

// File: rtl/id_sb_counter.sv
// Pending-write counter for one register: +inc, -dec (0..2), clear, saturating underflow flag.
module id_sb_counter #(
  parameter int unsigned CW = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clk_en_i,
  input  logic          inc_i,
  input  logic [1:0]    dec_i,
  input  logic          clear_i,
  output logic [CW-1:0] cnt_o,
  output logic          uflow_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW+1:0] sum;

  always_comb begin
    sum     = (CW+2)'(cnt_q) + (CW+2)'(inc_i);
    cnt_d   = cnt_q;
    uflow_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (sum < (CW+2)'(dec_i)) begin
      cnt_d   = '0;
      uflow_o = 1'b1;
    end else begin
      cnt_d = CW'(sum - (CW+2)'(dec_i));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       cnt_q <= '0;
    else if (clk_en_i) cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/id_scoreboard.sv
// Register write scoreboard: blocks issue on RAW hazards and full pending counters.
// Optional ID_SCOREBOARD_BYPASS_EN lets a source issue when all its pending writes retire this cycle.
module id_scoreboard
  import id_pkg::*;
#(
  parameter int unsigned C_NREGS    = C_NREGS_DEF,
  parameter int unsigned C_MAX_PEND = C_MAX_PEND_DEF
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clk_en_i,
  id_scoreboard_if.slave  sb
);
  localparam int unsigned CW = $clog2(C_MAX_PEND + 1);

  logic [CW-1:0]      cnt [C_NREGS];
  logic [C_NREGS-1:0] uflow, nz;
  logic               stall1, stall2, rd_full, ready, issue;
  logic               err_q, err_d;

  always_comb begin
`ifdef ID_SCOREBOARD_BYPASS_EN
    stall1 = sb.rs1_rd_i && (sb.rs1_addr_i != '0) &&
             (32'(cnt[sb.rs1_addr_i]) > 32'(wb_hits(sb.rs1_addr_i, sb.wb_a_wr_i, sb.wb_a_addr_i,
                                                    sb.wb_b_wr_i, sb.wb_b_addr_i)));
    stall2 = sb.rs2_rd_i && (sb.rs2_addr_i != '0) &&
             (32'(cnt[sb.rs2_addr_i]) > 32'(wb_hits(sb.rs2_addr_i, sb.wb_a_wr_i, sb.wb_a_addr_i,
                                                    sb.wb_b_wr_i, sb.wb_b_addr_i)));
`else
    stall1 = sb.rs1_rd_i && (sb.rs1_addr_i != '0) && (cnt[sb.rs1_addr_i] != '0);
    stall2 = sb.rs2_rd_i && (sb.rs2_addr_i != '0) && (cnt[sb.rs2_addr_i] != '0);
`endif
    rd_full = sb.rd_wr_i && (sb.rd_addr_i != '0) && (32'(cnt[sb.rd_addr_i]) >= C_MAX_PEND);
    ready   = !sb.flush_i && !stall1 && !stall2 && !rd_full;
    issue   = sb.issue_valid_i && ready && clk_en_i;
  end

  // x0 is never tracked: constant zero count, no counter instance.
  assign cnt[0]   = '0;
  assign uflow[0] = 1'b0;
  assign nz[0]    = 1'b0;

  for (genvar i = 1; i < C_NREGS; i++) begin : g_cnt
    logic       inc;
    logic [1:0] dec;
    assign inc = issue && sb.rd_wr_i && (sb.rd_addr_i == AW'(i));
    assign dec = wb_hits(AW'(i), sb.wb_a_wr_i, sb.wb_a_addr_i, sb.wb_b_wr_i, sb.wb_b_addr_i);
    id_sb_counter #(.CW(CW)) u_cnt (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clk_en_i (clk_en_i),
      .inc_i    (inc),
      .dec_i    (dec),
      .clear_i  (sb.flush_i),
      .cnt_o    (cnt[i]),
      .uflow_o  (uflow[i])
    );
    assign nz[i] = (cnt[i] != '0);
  end

  assign err_d = err_q | (|uflow);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       err_q <= 1'b0;
    else if (clk_en_i) err_q <= err_d;
  end

  assign sb.issue_ready_o = ready;
  assign sb.hazard_o      = sb.issue_valid_i && !ready;
  assign sb.busy_o        = |nz;
  assign sb.err_o         = err_q;
endmodule
